// File: rtl/reservation_station.sv
// Reservation station: holds renamed ops until their operands arrive over the CDB,
// then issues the oldest ready entry through a single registered output stage.
module reservation_station #(
    parameter int unsigned RS_SIZE    = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned OP_WIDTH   = 6,
    parameter int unsigned CDB_CH     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OP_WIDTH-1:0]            in_op,
    input  logic [ROB_WIDTH-1:0]           in_Qj,
    input  logic [ROB_WIDTH-1:0]           in_Qk,
    input  logic [DATA_WIDTH-1:0]          in_Vj,
    input  logic [DATA_WIDTH-1:0]          in_Vk,
    input  logic [DATA_WIDTH-1:0]          in_imm,
    input  logic [DATA_WIDTH-1:0]          in_pc,
    input  logic [ROB_WIDTH-1:0]           in_rob_tag,
    input  logic [CDB_CH-1:0]              cdb_valid,
    input  logic [CDB_CH*ROB_WIDTH-1:0]    cdb_tag,
    input  logic [CDB_CH*DATA_WIDTH-1:0]   cdb_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OP_WIDTH-1:0]            out_op,
    output logic [DATA_WIDTH-1:0]          out_Vj,
    output logic [DATA_WIDTH-1:0]          out_Vk,
    output logic [DATA_WIDTH-1:0]          out_imm,
    output logic [DATA_WIDTH-1:0]          out_pc,
    output logic [ROB_WIDTH-1:0]           out_rob_tag,
    output logic [$clog2(RS_SIZE+1)-1:0]   count,
    output logic                           empty
);

    localparam int unsigned CW = $clog2(RS_SIZE + 1);
    localparam int unsigned IW = $clog2(RS_SIZE);

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [ROB_WIDTH-1:0]  qj;
        logic [ROB_WIDTH-1:0]  qk;
        logic [DATA_WIDTH-1:0] vj;
        logic [DATA_WIDTH-1:0] vk;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] pc;
        logic [ROB_WIDTH-1:0]  rob_tag;
    } entry_t;

    entry_t               ent_q   [RS_SIZE];
    logic [RS_SIZE-1:0]   valid_q;
    // older_q[i][j] set means entry i was allocated before entry j
    logic [RS_SIZE-1:0]   older_q [RS_SIZE];

    logic [RS_SIZE-1:0]   rdy;
    logic [RS_SIZE-1:0]   blk;
    logic [RS_SIZE-1:0]   sel;
    logic [IW-1:0]        iss_idx;
    logic [IW-1:0]        free_idx;
    logic                 alloc;
    logic                 issue;
    entry_t               new_ent;

    // Capture a pending operand from the CDB; the lowest matching channel wins.
    function automatic logic [ROB_WIDTH+DATA_WIDTH-1:0] snoop(
        input logic [ROB_WIDTH-1:0]  q,
        input logic [DATA_WIDTH-1:0] v
    );
        logic [ROB_WIDTH+DATA_WIDTH-1:0] r;
        r = {q, v};
        if (q != '0) begin
            for (int c = int'(CDB_CH) - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (cdb_tag[c*ROB_WIDTH +: ROB_WIDTH] == q))
                    r = {ROB_WIDTH'(0), cdb_data[c*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
        return r;
    endfunction

    assign in_ready = (count != CW'(RS_SIZE));
    assign empty    = (count == '0);
    assign alloc    = in_valid && in_ready && !in_flush;
    assign issue    = (|rdy) && (!out_valid || out_ready);

    // Ready vector, oldest-ready select, free-slot search and bypassed new entry
    always_comb begin
        rdy      = '0;
        blk      = '0;
        sel      = '0;
        iss_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < int'(RS_SIZE); i++)
            rdy[i] = valid_q[i] && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            for (int j = 0; j < int'(RS_SIZE); j++) begin
                if (older_q[j][i] && rdy[j])
                    blk[i] = 1'b1;
            end
            sel[i] = rdy[i] && !blk[i];
        end
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (sel[i])
                iss_idx = IW'(i);
        end
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!valid_q[i])
                free_idx = IW'(i);
        end
        new_ent         = '0;
        new_ent.op      = in_op;
        new_ent.imm     = in_imm;
        new_ent.pc      = in_pc;
        new_ent.rob_tag = in_rob_tag;
        {new_ent.qj, new_ent.vj} = snoop(in_Qj, in_Vj);
        {new_ent.qk, new_ent.vk} = snoop(in_Qk, in_Vk);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_Vj      <= '0;
            out_Vk      <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_rob_tag <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                older_q[i] <= '0;
                ent_q[i]   <= '0;
            end
        end else if (in_flush) begin
            valid_q   <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (valid_q[i]) begin
                    {ent_q[i].qj, ent_q[i].vj} <= snoop(ent_q[i].qj, ent_q[i].vj);
                    {ent_q[i].qk, ent_q[i].vk} <= snoop(ent_q[i].qk, ent_q[i].vk);
                end
            end
            if (issue) begin
                valid_q[iss_idx] <= 1'b0;
                out_valid        <= 1'b1;
                out_op           <= ent_q[iss_idx].op;
                out_Vj           <= ent_q[iss_idx].vj;
                out_Vk           <= ent_q[iss_idx].vk;
                out_imm          <= ent_q[iss_idx].imm;
                out_pc           <= ent_q[iss_idx].pc;
                out_rob_tag      <= ent_q[iss_idx].rob_tag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // New entry is younger than everything currently held
            if (alloc) begin
                valid_q[free_idx] <= 1'b1;
                ent_q[free_idx]   <= new_ent;
                older_q[free_idx] <= '0;
                for (int j = 0; j < int'(RS_SIZE); j++)
                    older_q[j][free_idx] <= valid_q[j];
            end
            count <= count + CW'(alloc) - CW'(issue);
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: directed stimulus pushes expected
// issues, a negedge monitor pops and compares every accepted output.
module tb_reservation_station;

    localparam int unsigned RS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_flush, in_valid, in_ready;
    logic [5:0]  in_op;
    logic [3:0]  in_Qj, in_Qk, in_rob_tag;
    logic [31:0] in_Vj, in_Vk, in_imm, in_pc;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        out_valid, out_ready;
    logic [5:0]  out_op;
    logic [31:0] out_Vj, out_Vk, out_imm, out_pc;
    logic [3:0]  out_rob_tag;
    logic [3:0]  count;
    logic        empty;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    reservation_station #(
        .RS_SIZE(RS), .DATA_WIDTH(32), .ROB_WIDTH(4), .OP_WIDTH(6), .CDB_CH(2)
    ) dut (
        .clk(clk), .rst(rst), .in_flush(in_flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_op(in_op), .in_Qj(in_Qj), .in_Qk(in_Qk),
        .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm), .in_pc(in_pc),
        .in_rob_tag(in_rob_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_Vj(out_Vj), .out_Vk(out_Vk), .out_imm(out_imm),
        .out_pc(out_pc), .out_rob_tag(out_rob_tag), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] op, input logic [31:0] vj,
                                input logic [31:0] vk, input logic [3:0] tag);
        exp_t e;
        e.op  = op;
        e.vj  = vj;
        e.vk  = vk;
        e.imm = 32'h1000 + 32'(op);
        e.pc  = 32'h4000 + 32'(tag);
        e.tag = tag;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alloc(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                               input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] tag);
        in_valid   = 1'b1;
        in_op      = op;
        in_Qj      = qj;
        in_Qk      = qk;
        in_Vj      = vj;
        in_Vk      = vk;
        in_rob_tag = tag;
        in_imm     = 32'h1000 + 32'(op);
        in_pc      = 32'h4000 + 32'(tag);
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic bcast(input logic [1:0] v, input logic [3:0] t1, input logic [3:0] t0,
                         input logic [31:0] d1, input logic [31:0] d0);
        cdb_valid = v;
        cdb_tag   = {t1, t0};
        cdb_data  = {d1, d0};
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every accepted output must match the oldest expected issue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t got, e;
            got = '{op: out_op, vj: out_Vj, vk: out_Vk, imm: out_imm, pc: out_pc, tag: out_rob_tag};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got op=%0h tag=%0h vj=%0h, expected nothing",
                         out_op, out_rob_tag, out_Vj);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL issue: got op=%0h vj=%0h vk=%0h imm=%0h pc=%0h tag=%0h expected op=%0h vj=%0h vk=%0h imm=%0h pc=%0h tag=%0h",
                             got.op, got.vj, got.vk, got.imm, got.pc, got.tag,
                             e.op, e.vj, e.vk, e.imm, e.pc, e.tag);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_Qj = '0; in_Qk = '0; in_Vj = '0; in_Vk = '0;
        in_imm = '0; in_pc = '0; in_rob_tag = '0;
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        #10 rst = 1'b0;
        tick();

        // V1: ready-at-allocation entry issues one edge later
        sb.push_back(mk(6'd1, 32'd5, 32'd7, 4'd3));
        drive_alloc(6'd1, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3);
        check("v1_count_alloc", 64'(count), 64'd1);
        check("v1_not_yet", 64'(out_valid), 64'd0);
        tick();
        check("v1_out_valid", 64'(out_valid), 64'd1);
        check("v1_count_after", 64'(count), 64'd0);
        tick();
        check("v1_out_clear", 64'(out_valid), 64'd0);

        // V2: wakeup on CDB channel 1 two edges after allocation
        drive_alloc(6'd2, 4'd2, 4'd0, 32'd0, 32'h22, 4'd5);
        tick();
        check("v2_waiting", 64'(out_valid), 64'd0);
        bcast(2'b10, 4'd2, 4'd0, 32'hAB, 32'd0);
        sb.push_back(mk(6'd2, 32'hAB, 32'h22, 4'd5));
        tick();
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        check("v2_woken_not_issued", 64'(out_valid), 64'd0);
        tick();
        check("v2_issued", 64'(out_valid), 64'd1);
        tick();

        // V3: bypass at allocation
        bcast(2'b01, 4'd0, 4'd4, 32'd0, 32'd9);
        sb.push_back(mk(6'd3, 32'd9, 32'h33, 4'd6));
        drive_alloc(6'd3, 4'd4, 4'd0, 32'd0, 32'h33, 4'd6);
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        check("v3_count", 64'(count), 64'd1);
        tick();
        check("v3_issued", 64'(out_valid), 64'd1);
        tick();

        // Both sources on one tag; both channels match, channel 0 wins
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        drive_alloc(6'd4, 4'hA, 4'hA, 32'd0, 32'd0, 4'd7);
        bcast(2'b11, 4'hA, 4'hA, 32'h77, 32'h55);
        sb.push_back(mk(6'd4, 32'h55, 32'h55, 4'd7));
        tick();
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        wait_drain("dual_drain", 10);

        // V4: fill, refuse when full, drain in allocation order
        for (int i = 0; i < int'(RS); i++)
            drive_alloc(6'(8 + i), 4'd6, 4'd0, 32'd0, 32'(i), 4'(8 + i));
        check("v4_in_ready", 64'(in_ready), 64'd0);
        check("v4_count_full", 64'(count), 64'(RS));
        drive_alloc(6'h3F, 4'd0, 4'd0, 32'd1, 32'd1, 4'd1);
        check("v4_count_still_full", 64'(count), 64'(RS));
        for (int i = 0; i < int'(RS); i++)
            sb.push_back(mk(6'(8 + i), 32'h66, 32'(i), 4'(8 + i)));
        bcast(2'b01, 4'd0, 4'd6, 32'd0, 32'h66);
        tick();
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        wait_drain("v4_drain", 20);
        tick();
        check("v4_count_empty", 64'(count), 64'd0);

        // V5: backpressure holds the output stage
        out_ready = 1'b0;
        drive_alloc(6'd20, 4'd0, 4'd0, 32'h100, 32'h101, 4'd1);
        drive_alloc(6'd21, 4'd0, 4'd0, 32'h200, 32'h201, 4'd2);
        check("v5_loaded", 64'(out_valid), 64'd1);
        check("v5_count", 64'(count), 64'd1);
        tick();
        tick();
        check("v5_hold_tag", 64'(out_rob_tag), 64'd1);
        check("v5_hold_vj", 64'(out_Vj), 64'h100);
        check("v5_hold_count", 64'(count), 64'd1);
        sb.push_back(mk(6'd20, 32'h100, 32'h101, 4'd1));
        sb.push_back(mk(6'd21, 32'h200, 32'h201, 4'd2));
        out_ready = 1'b1;
        tick();
        check("v5_second_tag", 64'(out_rob_tag), 64'd2);
        wait_drain("v5_drain", 5);
        tick();

        // Age order beats slot order: younger Z reuses slot 0, older Y in slot 1
        drive_alloc(6'd30, 4'd5, 4'd0, 32'd0, 32'd1, 4'd1);
        drive_alloc(6'd31, 4'd7, 4'd0, 32'd0, 32'd2, 4'd2);
        bcast(2'b01, 4'd0, 4'd5, 32'd0, 32'h50);
        sb.push_back(mk(6'd30, 32'h50, 32'd1, 4'd1));
        tick();
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        tick();
        drive_alloc(6'd32, 4'd7, 4'd0, 32'd0, 32'd3, 4'd3);
        sb.push_back(mk(6'd31, 32'h70, 32'd2, 4'd2));
        sb.push_back(mk(6'd32, 32'h70, 32'd3, 4'd3));
        bcast(2'b10, 4'd7, 4'd0, 32'h70, 32'd0);
        tick();
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        wait_drain("age_drain", 10);
        tick();

        // V6: flush beats a simultaneous allocation and clears a held output
        out_ready = 1'b0;
        drive_alloc(6'd40, 4'd0, 4'd0, 32'd4, 32'd4, 4'd4);
        for (int i = 0; i < 3; i++)
            drive_alloc(6'(41 + i), 4'd9, 4'd0, 32'd0, 32'd0, 4'(5 + i));
        check("v6_count_pending", 64'(count), 64'd3);
        check("v6_held", 64'(out_valid), 64'd1);
        in_flush = 1'b1;
        drive_alloc(6'd50, 4'd0, 4'd0, 32'd1, 32'd1, 4'd1);
        in_flush = 1'b0;
        out_ready = 1'b1;
        check("v6_count", 64'(count), 64'd0);
        check("v6_out_valid", 64'(out_valid), 64'd0);
        check("v6_empty", 64'(empty), 64'd1);
        bcast(2'b01, 4'd0, 4'd9, 32'd0, 32'h99);
        tick();
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        tick();
        check("v6_nothing_issued", 64'(out_valid), 64'd0);

        // Async reset mid-operation discards entries and held output
        out_ready = 1'b0;
        drive_alloc(6'd60, 4'd0, 4'd0, 32'd6, 32'd6, 4'd9);
        drive_alloc(6'd61, 4'hB, 4'd0, 32'd0, 32'd0, 4'd10);
        drive_alloc(6'd62, 4'hB, 4'd0, 32'd0, 32'd0, 4'd11);
        check("rst2_count_before", 64'(count), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("rst2_count", 64'(count), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_out_tag", 64'(out_rob_tag), 64'd0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        bcast(2'b01, 4'd0, 4'hB, 32'd0, 32'hBB);
        tick();
        bcast(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        tick();
        check("rst2_nothing_issued", 64'(out_valid), 64'd0);
        sb.push_back(mk(6'd63, 32'd3, 32'd3, 4'd12));
        drive_alloc(6'd63, 4'd0, 4'd0, 32'd3, 32'd3, 4'd12);
        wait_drain("rst2_drain", 5);
        tick();
        check("final_empty", 64'(empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
- REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries (2..32).
- REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand/imm/PC width.
- REQ-003 SHALL have parameter ROB_WIDTH, default 4, ROB tag width; tag 0 means "no dependency".
- REQ-004 SHALL have parameter OP_WIDTH, default 6, operation code width.
- REQ-005 SHALL have parameter CDB_CH, default 2, number of CDB broadcast channels.
- REQ-006 SHALL have one clock; reset is asynchronous and active-high. Ports:
  clk  in  1  clock
  rst  in  1  async active-high reset
  in_flush  in  1  sync clear of all state (mispredict)
  in_valid  in  1  allocation request
  in_ready  out  1  accept allowed (=~full)
  in_op  in  OP_WIDTH  operation
  in_Qj, in_Qk  in  ROB_WIDTH  source tags
  in_Vj, in_Vk  in  DATA_WIDTH  source values (used when tag 0)
  in_imm, in_pc  in  DATA_WIDTH  immediate, PC
  in_rob_tag  in  ROB_WIDTH  destination tag
  cdb_valid  in  CDB_CH  per-channel broadcast valid
  cdb_tag  in  CDB_CH*ROB_WIDTH  channel c at bits [c*ROB_WIDTH +: ROB_WIDTH]
  cdb_data  in  CDB_CH*DATA_WIDTH  same packing
  out_valid  out  1  issue valid
  out_ready  in  1  execution unit accepts
  out_op, out_Vj, out_Vk, out_imm, out_pc, out_rob_tag  out  per field  issued entry
  count  out  $clog2(RS_SIZE+1)  occupied entries
  empty  out  1  count==0

Function
- REQ-007 SHALL accept an allocation on a clk edge iff in_valid && in_ready && !in_flush; entry written into the lowest-index free slot.
- REQ-008 in_ready SHALL be combinational ~full from registered occupancy; no allocation when full even if an issue occurs the same cycle.
- REQ-009 On allocation, each source SHALL bypass the CDB: if in_Qx!=0 and matches a valid channel this cycle, store Qx=0, Vx=that channel's data.
- REQ-010 Each stored entry with Qx!=0 SHALL wake up on an edge where cdb_valid[c] && cdb_tag[c]==Qx: Qx<=0, Vx<=cdb_data[c]; lowest c wins if multiple match.
- REQ-011 Entry SHALL be ready when valid && Qj==0 && Qk==0 (registered values only).
- REQ-012 Issue selection SHALL pick the oldest ready entry by allocation order (age matrix or equivalent), independent of slot index.
- REQ-013 Output register SHALL load on an edge when a ready entry exists and (!out_valid || out_ready); the chosen entry is freed on that same edge.
- REQ-014 out_valid && !out_ready SHALL hold all out_* stable; out_valid && out_ready with no ready entry SHALL clear out_valid.
- REQ-015 Latency: entry allocated ready at edge N SHALL appear on out_* after edge N+1; CDB wakeup at edge N, issue after edge N+1.
- REQ-016 count SHALL update by +alloc -issue each edge; simultaneous alloc and issue leaves count unchanged.
- REQ-017 in_flush SHALL, on the next edge, clear all entry valids, out_valid and count; flush overrides allocation, wakeup and issue that cycle.
- REQ-018 Entries freed by issue SHALL be reusable by allocation on the following edge.
- REQ-019 in_Qj==in_Qk nonzero SHALL wake both sources from one broadcast.

Reset
- REQ-020 rst high SHALL immediately clear all entry valids, age state, out_valid=0, count=0, empty=1, in_ready=1; out_* data fields 0.
- REQ-021 Reset asserted mid-operation SHALL discard all pending entries and any held output; first allocation after deassert goes to slot 0.

Verification
- V1: reset, alloc op=ADD Qj=Qk=0 Vj=5 Vk=7 tag=3, out_ready=1 -> out_valid after next edge, out_Vj=5, out_Vk=7, out_rob_tag=3, count back to 0.
- V2: alloc Qj=2; two edges later cdb_valid[1]=1 tag=2 data=0xAB -> issue one edge later with out_Vj=0xAB.
- V3: alloc Qj=4 while same cycle cdb tag=4 data=9 -> entry stored ready, issues next edge with Vj=9.
- V4: fill RS_SIZE entries (all waiting tag 6) -> in_ready=0, count=RS_SIZE; broadcast tag 6 -> issued in allocation order, one per cycle, out_ready=1.
- V5: out_ready=0 with two ready entries -> out_* stable, count=1 after first load; out_ready=1 -> second issued next edge.
- V6: 3 entries pending, assert in_flush one cycle together with in_valid -> count=0, out_valid=0, new request not stored.
